// File: rtl/reg_file_param_if.sv
// Register-file access bundle: write port, two read ports, PC control and
// flush handshake. The master drives requests; the register file is the slave.
interface reg_file_param_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 4
);
   logic             WE;
   logic [AW-1:0]    WA;
   logic [WIDTH-1:0] WD;
   logic [AW-1:0]    RA0;
   logic [AW-1:0]    RA1;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             PC_INC;
   logic [WIDTH-1:0] PC;
   logic             FLUSH;
   logic             BUSY;
   logic             DONE;

   modport master (
      output WE, WA, WD, RA0, RA1, PC_INC, FLUSH,
      input  A, B, PC, BUSY, DONE
   );

   modport slave (
      input  WE, WA, WD, RA0, RA1, PC_INC, FLUSH,
      output A, B, PC, BUSY, DONE
   );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with two combinational read ports, write-to-read
// bypass, an auto-incrementing program-counter register and a sequential
// flush engine that zeroes one register per clock.
module reg_file_param #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned PC_IDX  = DEPTH - 1,
   parameter int unsigned PC_STEP = 4,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input logic             CLK,
   input logic             CLR,
   reg_file_param_if.slave bus
);

   typedef enum logic [1:0] {
      stIdle,
      stClear,
      stDone
   } stateT;

   localparam logic [AW-1:0]    PC_ADDR  = AW'(PC_IDX);
   localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);
   localparam logic [WIDTH-1:0] STEP     = WIDTH'(PC_STEP);

   logic [WIDTH-1:0] regs [DEPTH];
   stateT            state;
   stateT            stateNext;
   logic [AW-1:0]    ptr;
   logic [AW-1:0]    ptrNext;
   logic             flushAccept;
   logic             updEn;
   logic             bypassEn;
   logic [WIDTH-1:0] pcNext;

   // A flush accepted in IDLE swallows any write or increment on the same edge.
   assign flushAccept = (state == stIdle) && bus.FLUSH;
   assign updEn       = (state != stClear) && !flushAccept;
   // Gating with CLR keeps the outputs at zero while reset is held.
   assign bypassEn    = CLR && bus.WE && updEn;
   assign pcNext      = regs[PC_ADDR] + STEP;

   // FSM state and clear pointer register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state <= stIdle;
         ptr   <= '0;
      end else begin
         state <= stateNext;
         ptr   <= ptrNext;
      end
   end

   // Next-state logic for the flush sequencer.
   always_comb begin
      stateNext = state;
      ptrNext   = ptr;
      unique case (state)
         stIdle: begin
            if (bus.FLUSH) begin
               stateNext = stClear;
               ptrNext   = '0;
            end
         end
         stClear: begin
            ptrNext = ptr + AW'(1);
            if (ptr == LAST_PTR) begin
               stateNext = stDone;
            end
         end
         stDone: begin
            stateNext = stIdle;
         end
         default: begin
            stateNext = stIdle;
         end
      endcase
   end

   // Register storage: flush clear, then write (which beats a PC increment).
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (state == stClear) begin
               if (ptr == AW'(i)) begin
                  regs[i] <= '0;
               end
            end else if (updEn) begin
               if (bus.WE && (bus.WA == AW'(i))) begin
                  regs[i] <= bus.WD;
               end else if (bus.PC_INC && (AW'(i) == PC_ADDR)) begin
                  regs[i] <= pcNext;
               end
            end
         end
      end
   end

   // Combinational read ports with same-cycle write bypass.
   always_comb begin
      bus.A = regs[bus.RA0];
      bus.B = regs[bus.RA1];
      if (bypassEn && (bus.WA == bus.RA0)) begin
         bus.A = bus.WD;
      end
      if (bypassEn && (bus.WA == bus.RA1)) begin
         bus.B = bus.WD;
      end
   end

   assign bus.PC   = regs[PC_ADDR];
   assign bus.BUSY = (state == stClear);
   assign bus.DONE = (state == stDone);

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed vector table, flush and
// reset corner sequences, randomized traffic against a behavioural model, and
// a small-parameter instance for the sweep case.
module tb_reg_file_param;

   localparam int unsigned D    = 16;
   localparam int unsigned PCI  = 15;
   localparam int unsigned STEP = 4;

   logic CLK = 1'b0;
   logic CLR;

   always #5 CLK = ~CLK;

   reg_file_param_if #(.WIDTH(32), .AW(4)) bus ();
   reg_file_param #(.WIDTH(32), .DEPTH(16), .PC_IDX(15), .PC_STEP(4)) dut (
      .CLK(CLK), .CLR(CLR), .bus(bus)
   );

   reg_file_param_if #(.WIDTH(16), .AW(3)) bus2 ();
   reg_file_param #(.WIDTH(16), .DEPTH(8), .PC_STEP(2)) dut2 (
      .CLK(CLK), .CLR(CLR), .bus(bus2)
   );

   // Behavioural model: register contents, clear edges still to run, done flag.
   logic [31:0] mem [D];
   int          clrLeft;
   bit          doneFlag;

   int nVec  = 0;
   int nFail = 0;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic        pcInc;
      logic [31:0] eA;
      logic [31:0] eB;
      logic [31:0] ePC;
   } vecT;

   vecT tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < D; i++) mem[i] = '0;
      clrLeft  = 0;
      doneFlag = 1'b0;
   endtask

   task automatic modelEdge(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                            input logic pcInc, input logic flush);
      if (clrLeft > 0) begin
         mem[D - clrLeft] = '0;
         clrLeft--;
         if (clrLeft == 0) doneFlag = 1'b1;
      end else begin
         if (flush && !doneFlag) begin
            clrLeft = D;
         end else begin
            if (pcInc) mem[PCI] = mem[PCI] + STEP;
            if (we) mem[wa] = wd;
         end
         doneFlag = 1'b0;
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] ra0, input logic [3:0] ra1,
                        input logic pcInc, input logic flush);
      bus.WE     = we;
      bus.WA     = wa;
      bus.WD     = wd;
      bus.RA0    = ra0;
      bus.RA1    = ra1;
      bus.PC_INC = pcInc;
      bus.FLUSH  = flush;
   endtask

   // One clock of model-checked traffic; entered and left just after a rising edge.
   task automatic cycle(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] ra0, input logic [3:0] ra1,
                        input logic pcInc, input logic flush);
      bit          upd;
      logic [31:0] expA;
      logic [31:0] expB;
      drive(we, wa, wd, ra0, ra1, pcInc, flush);
      #1;
      upd  = (clrLeft == 0) && !(flush && !doneFlag);
      expA = (upd && we && (wa == ra0)) ? wd : mem[ra0];
      expB = (upd && we && (wa == ra1)) ? wd : mem[ra1];
      check("A", bus.A, expA);
      check("B", bus.B, expB);
      check("PC", bus.PC, mem[PCI]);
      check("BUSY", 32'(bus.BUSY), 32'(clrLeft > 0));
      check("DONE", 32'(bus.DONE), 32'(doneFlag));
      @(posedge CLK);
      modelEdge(we, wa, wd, pcInc, flush);
      #1;
   endtask

   task automatic fillAll(input logic [31:0] tag);
      for (int i = 0; i < D; i++) begin
         cycle(1'b1, 4'(i), tag | 32'(i + 1), 4'(i), 4'((i + 1) % D), 1'b0, 1'b0);
      end
   endtask

   initial begin
      int          busyCnt;
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic        pcInc;
      logic        flush;

      tbl[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 4'd3,  4'd0,  1'b0, 32'hDEADBEEF, 32'h0,        32'h0};
      tbl[1] = '{1'b0, 4'd0,  32'h0,        4'd3,  4'd3,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
      tbl[2] = '{1'b1, 4'd5,  32'h1234,     4'd0,  4'd5,  1'b0, 32'h0,        32'h1234,     32'h0};
      tbl[3] = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd5,  1'b0, 32'h1234,     32'h1234,     32'h0};
      tbl[4] = '{1'b1, 4'd15, 32'hFFFFFFFC, 4'd15, 4'd15, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0};
      tbl[5] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd3,  1'b1, 32'hFFFFFFFC, 32'hDEADBEEF, 32'hFFFFFFFC};
      tbl[6] = '{1'b1, 4'd15, 32'h100,      4'd15, 4'd15, 1'b1, 32'h100,      32'h100,      32'h0};
      tbl[7] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd1,  1'b0, 32'h100,      32'h0,        32'h100};
      tbl[8] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd15, 1'b1, 32'h100,      32'h100,      32'h100};
      tbl[9] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd2,  1'b0, 32'h104,      32'h0,        32'h104};

      bus2.WE = 1'b0; bus2.WA = '0; bus2.WD = '0; bus2.RA0 = '0; bus2.RA1 = '0;
      bus2.PC_INC = 1'b0; bus2.FLUSH = 1'b0;

      // Reset: outputs held at zero even with a bypassing write presented.
      CLR = 1'b0;
      drive(1'b1, 4'd3, 32'h55AA55AA, 4'd3, 4'd3, 1'b1, 1'b0);
      #12;
      check("rst A", bus.A, 32'h0);
      check("rst B", bus.B, 32'h0);
      check("rst PC", bus.PC, 32'h0);
      check("rst BUSY", 32'(bus.BUSY), 32'h0);
      check("rst DONE", 32'(bus.DONE), 32'h0);
      drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      CLR = 1'b1;
      modelReset();
      @(posedge CLK); #1;

      // Directed vectors: write/read, bypass, PC increment/wrap, write beats increment.
      for (int v = 0; v < 10; v++) begin
         drive(tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ra0, tbl[v].ra1, tbl[v].pcInc, 1'b0);
         #1;
         check($sformatf("vec%0d A", v), bus.A, tbl[v].eA);
         check($sformatf("vec%0d B", v), bus.B, tbl[v].eB);
         check($sformatf("vec%0d PC", v), bus.PC, tbl[v].ePC);
         @(posedge CLK);
         modelEdge(tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].pcInc, 1'b0);
         #1;
      end

      // Full flush with writes and increments hammered throughout the clear.
      fillAll(32'hA5000000);
      cycle(1'b1, 4'd6, 32'h77777777, 4'd6, 4'd6, 1'b1, 1'b1);
      busyCnt = 0;
      while (bus.BUSY && busyCnt < 40) begin
         busyCnt++;
         wa = 4'($urandom_range(0, 15));
         cycle(1'b1, wa, 32'hF0F0F0F0, wa, 4'(busyCnt - 1), 1'b1, 1'b1);
      end
      check("flush busy cycles", 32'(busyCnt), 32'd16);
      check("flush DONE pulse", 32'(bus.DONE), 32'd1);
      cycle(1'b0, 4'd0, 32'h0, 4'd0, 4'd15, 1'b0, 1'b1);
      check("flush DONE drop", 32'(bus.DONE), 32'd0);
      check("flush refused in DONE", 32'(bus.BUSY), 32'd0);
      for (int i = 0; i < D; i++) cycle(1'b0, 4'd0, 32'h0, 4'(i), 4'(D - 1 - i), 1'b0, 1'b0);

      // Reset asserted with the clear pointer at 7 aborts the flush.
      fillAll(32'h3C000000);
      cycle(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b0, 4'd0, 32'h0, 4'd10, 4'd15, 1'b0, 1'b0);
      drive(1'b1, 4'd12, 32'h99999999, 4'd12, 4'd10, 1'b1, 1'b0);
      CLR = 1'b0;
      #1;
      check("abort BUSY", 32'(bus.BUSY), 32'h0);
      check("abort DONE", 32'(bus.DONE), 32'h0);
      check("abort A", bus.A, 32'h0);
      check("abort B", bus.B, 32'h0);
      check("abort PC", bus.PC, 32'h0);
      modelReset();
      @(posedge CLK); #1;
      check("abort DONE held", 32'(bus.DONE), 32'h0);
      drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      #2;
      CLR = 1'b1;
      @(posedge CLK); #1;
      for (int i = 0; i < D; i++) cycle(1'b0, 4'd0, 32'h0, 4'(i), 4'(i), 1'b0, 1'b0);
      cycle(1'b1, 4'd2, 32'hCAFEF00D, 4'd0, 4'd1, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 32'h0, 4'd2, 4'd2, 1'b0, 1'b0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         we    = 1'($urandom_range(0, 1));
         wa    = 4'($urandom_range(0, 15));
         wd    = $urandom;
         ra0   = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
         ra1   = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
         pcInc = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) ra1 = 4'(PCI);
         cycle(we, wa, wd, ra0, ra1, pcInc, flush);
      end
      drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);

      // Narrow instance: PC wrap by 2 and an eight-cycle flush.
      bus2.WE = 1'b1; bus2.WA = 3'd7; bus2.WD = 16'hFFFE; bus2.RA0 = 3'd7; bus2.RA1 = 3'd1;
      @(posedge CLK); #1;
      bus2.WE = 1'b0; bus2.PC_INC = 1'b1;
      #1;
      check("w16 PC before wrap", 32'(bus2.PC), 32'h0000FFFE);
      @(posedge CLK); #1;
      bus2.PC_INC = 1'b0;
      #1;
      check("w16 PC wrapped", 32'(bus2.PC), 32'h0);
      check("w16 A wrapped", 32'(bus2.A), 32'h0);
      bus2.WE = 1'b1; bus2.WA = 3'd1; bus2.WD = 16'hBEEF;
      @(posedge CLK); #1;
      bus2.WE = 1'b0; bus2.FLUSH = 1'b1;
      #1;
      check("w16 B before flush", 32'(bus2.B), 32'h0000BEEF);
      @(posedge CLK); #1;
      bus2.FLUSH = 1'b0;
      busyCnt = 0;
      while (bus2.BUSY && busyCnt < 40) begin
         busyCnt++;
         @(posedge CLK); #1;
      end
      check("w16 flush busy cycles", 32'(busyCnt), 32'd8);
      check("w16 DONE pulse", 32'(bus2.DONE), 32'd1);
      @(posedge CLK); #1;
      check("w16 DONE drop", 32'(bus2.DONE), 32'd0);
      check("w16 B after flush", 32'(bus2.B), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
